edge_capture_n: RTL and testbench

- Parametrised successor to the single-byte rising-edge detector: WIDTH independent channels, run-time selectable edge polarity, sticky per-channel capture with clear, and a saturating event counter.
- Sits between raw status/strobe inputs and a polling or interrupt consumer.
- Produces a one-cycle edge pulse vector, latched capture bits, and a summary interrupt.

---
 rtl/edge_capture_pkg.sv | 36 +++
 rtl/edge_sat_counter.sv | 58 +++++
 rtl/edge_capture_n.sv | 155 +++++++++++++++
 tb/tb_edge_capture_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/edge_capture_pkg.sv
// -----------------------------------------------------------------------------
// edge_capture_pkg
//   Shared types and helpers for the edge_capture_n block.
//
//   Contents:
//     edge_mode_e  - run-time edge polarity select
//     popcount     - set-bit count of a vector (zero-extended to POP_MAX_W)
//
//   The package has no ports.
// -----------------------------------------------------------------------------
package edge_capture_pkg;

  // Edge polarity encoding as seen on the mode input.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  // popcount works on a fixed wide vector. Callers zero-extend their
  // WIDTH-bit vector with a size cast, so any WIDTH up to POP_MAX_W works.
  localparam int unsigned POP_MAX_W = 256;
  localparam int unsigned POP_CNT_W = 9;   // holds 0..256

  // Number of bits set in vec_i.
  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec_i);
    logic [POP_CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(POP_MAX_W); i++) begin
      acc = acc + POP_CNT_W'(vec_i[i]);
    end
    return acc;
  endfunction

endpackage : edge_capture_pkg

// File: rtl/edge_sat_counter.sv
// -----------------------------------------------------------------------------
// edge_sat_counter
//   CNT_W-bit accumulator that adds inc_i every clock, optionally restarting
//   from zero (clr_i), and clamps at the all-ones value. Once clamped it holds
//   until cleared.
//
//   Ports:
//     clk_i     in   1      clock, posedge
//     resetn_i  in   1      asynchronous active-low reset
//     clr_i     in   1      restart accumulation from zero this cycle
//     inc_i     in   CNT_W  amount to add this cycle
//     cnt_o     out  CNT_W  registered count
// -----------------------------------------------------------------------------
module edge_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base_s;
  logic [CNT_W:0]   sum_s;

  // Next count: the add is one bit wider, so its carry-out flags saturation.
  always_comb begin
    base_s = '0;
    sum_s  = '0;
    cnt_d  = cnt_q;
    if (clr_i) begin
      base_s = '0;
    end else begin
      base_s = cnt_q;
    end
    sum_s = {1'b0, base_s} + {1'b0, inc_i};
    if (sum_s[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum_s[CNT_W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : edge_sat_counter

// File: rtl/edge_capture_n.sv
// -----------------------------------------------------------------------------
// edge_capture_n
//   WIDTH-channel edge detector with run-time polarity select, sticky
//   per-channel capture bits with clear, a saturating total-event counter and
//   a summary interrupt.
//
//   Ports:
//     clk_i      in   1      clock, all state on posedge
//     resetn_i   in   1      asynchronous active-low reset
//     in_i       in   WIDTH  monitored signals
//     mode_i     in   2      00 rising, 01 falling, 10 both, 11 disabled
//     clr_i      in   WIDTH  per-channel capture clear
//     cnt_clr_i  in   1      event counter clear
//     pedge_o    out  WIDTH  registered one-cycle edge pulses
//     cap_o      out  WIDTH  sticky capture bits
//     cnt_o      out  CNT_W  saturating total edge count
//     irq_o      out  1      OR of cap_o
//
//   Build option:
//     EDGE_CAPTURE_SYNC_EN - when defined, in_i passes through a 2-flop
//     synchroniser per bit; edge pulses then appear 3 cycles after the input
//     change and detection is held off for 3 posedges after reset release.
//
//   Parameter constraint: 2**CNT_W-1 >= WIDTH (a full-width event must fit in
//   the counter increment), and WIDTH <= 256.
// -----------------------------------------------------------------------------
module edge_capture_n
  import edge_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] clr_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] pedge_o,
  output logic [WIDTH-1:0] cap_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             irq_o
);

  // Number of posedges after reset release before edges are reported. With
  // the synchroniser the pipeline must fill before prev holds real data.
`ifdef EDGE_CAPTURE_SYNC_EN
  localparam int unsigned PRIME_CYC = 3;
`else
  localparam int unsigned PRIME_CYC = 1;
`endif

  logic [WIDTH-1:0] din_s;       // input as seen by the edge logic
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pedge_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] ev_s;
  logic             primed_q;
  logic             primed_d;
  logic [1:0]       prime_cnt_q;
  logic [1:0]       prime_cnt_d;
  logic [CNT_W-1:0] inc_s;
  edge_mode_e       mode_s;

`ifdef EDGE_CAPTURE_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop synchroniser per channel.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  assign din_s = sync2_q;
`else
  assign din_s = in_i;
`endif

  // Priming: count posedges since reset release, then stick at primed.
  always_comb begin
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    if (!primed_q) begin
      if (prime_cnt_q == 2'(PRIME_CYC - 1)) begin
        primed_d = 1'b1;
      end else begin
        prime_cnt_d = prime_cnt_q + 2'd1;
      end
    end else begin
      primed_d = 1'b1;
    end
  end

  // Raw edge detection for the currently selected polarity, gated by primed.
  always_comb begin
    mode_s = edge_mode_e'(mode_i);
    raw_s  = '0;
    case (mode_s)
      EDGE_RISE: raw_s = din_s & ~prev_q;
      EDGE_FALL: raw_s = ~din_s & prev_q;
      EDGE_BOTH: raw_s = din_s ^ prev_q;
      EDGE_OFF:  raw_s = '0;
      default:   raw_s = '0;
    endcase
    ev_s = raw_s & {WIDTH{primed_q}};
  end

  // Sticky capture: a new event on a bit wins over its clear.
  always_comb begin
    cap_d = (cap_q & ~clr_i) | ev_s;
  end

  // Edge-detector state: previous input, pulse output, capture bits, priming.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      prev_q      <= '0;
      pedge_q     <= '0;
      cap_q       <= '0;
      primed_q    <= 1'b0;
      prime_cnt_q <= 2'd0;
    end else begin
      prev_q      <= din_s;
      pedge_q     <= ev_s;
      cap_q       <= cap_d;
      primed_q    <= primed_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  // Events this cycle; fits in CNT_W by the parameter constraint.
  assign inc_s = CNT_W'(popcount(POP_MAX_W'(ev_s)));

  edge_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (cnt_clr_i),
    .inc_i    (inc_s),
    .cnt_o    (cnt_o)
  );

  assign pedge_o = pedge_q;
  assign cap_o   = cap_q;
  assign irq_o   = |cap_q;

endmodule : edge_capture_n

// File: tb/tb_edge_capture_n.sv
// -----------------------------------------------------------------------------
// tb_edge_capture_n
//   Directed bench for edge_capture_n (WIDTH=8, CNT_W=4 so saturation is
//   reachable). The driver applies one vector per clock and queues the
//   hand-computed outputs expected after that posedge; a monitor pops and
//   compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_edge_capture_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic [7:0] pedge;
    logic [7:0] cap;
    logic [3:0] cnt;
    logic       irq;
    string      tag;
  } exp_t;

  logic             clk;
  logic             resetn;
  logic [WIDTH-1:0] in_v;
  logic [1:0]       mode;
  logic [WIDTH-1:0] clr;
  logic             cnt_clr;
  logic [WIDTH-1:0] pedge;
  logic [WIDTH-1:0] cap;
  logic [CNT_W-1:0] cnt;
  logic             irq;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  edge_capture_n #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .in_i      (in_v),
    .mode_i    (mode),
    .clr_i     (clr),
    .cnt_clr_i (cnt_clr),
    .pedge_o   (pedge),
    .cap_o     (cap),
    .cnt_o     (cnt),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pedge"}, 32'(pedge), 32'd0);
    chk({tag, ".cap"},   32'(cap),   32'd0);
    chk({tag, ".cnt"},   32'(cnt),   32'd0);
    chk({tag, ".irq"},   32'(irq),   32'd0);
  endtask

  // Apply a vector from a negedge, queue expected outputs after the posedge.
  task automatic step(input logic [7:0] i_v, input logic [1:0] m, input logic [7:0] c,
                      input logic cc, input logic [7:0] e_pedge, input logic [7:0] e_cap,
                      input logic [3:0] e_cnt, input logic e_irq, input string tag);
    exp_t e;
    in_v    = i_v;
    mode    = m;
    clr     = c;
    cnt_clr = cc;
    @(posedge clk);
    e.pedge = e_pedge;
    e.cap   = e_cap;
    e.cnt   = e_cnt;
    e.irq   = e_irq;
    e.tag   = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare queued expectations against the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".pedge"}, 32'(pedge), 32'(e.pedge));
        chk({e.tag, ".cap"},   32'(cap),   32'(e.cap));
        chk({e.tag, ".cnt"},   32'(cnt),   32'(e.cnt));
        chk({e.tag, ".irq"},   32'(irq),   32'(e.irq));
      end
    end
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    resetn  = 1'b0;
    in_v    = 8'hFF;
    mode    = 2'b00;
    clr     = 8'h00;
    cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("in_reset");
    @(negedge clk);
    resetn = 1'b1;

    // Priming: inputs already high at release must not produce edges.
    step(8'hFF, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "prime0");
    step(8'hFF, 2'b10, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "prime1");
    step(8'hFF, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "prime2");

    // Rising edges.
    step(8'h00, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "rise_fall_ignored");
    step(8'h01, 2'b00, 8'h00, 1'b0, 8'h01, 8'h01, 4'd1, 1'b1, "rise_pulse");
    step(8'h01, 2'b00, 8'h00, 1'b0, 8'h00, 8'h01, 4'd1, 1'b1, "rise_one_cycle");
    step(8'h00, 2'b00, 8'hFF, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, "rise_then_clear");

    // Both edges on consecutive clocks.
    step(8'h06, 2'b10, 8'h00, 1'b0, 8'h06, 8'h06, 4'd2, 1'b1, "both_up");
    step(8'h00, 2'b10, 8'h00, 1'b0, 8'h06, 8'h06, 4'd4, 1'b1, "both_down");
    step(8'h00, 2'b10, 8'h00, 1'b0, 8'h00, 8'h06, 4'd4, 1'b1, "both_idle");

    // Falling, disabled, and an immediate mode change.
    step(8'h03, 2'b01, 8'h00, 1'b0, 8'h00, 8'h06, 4'd4, 1'b1, "fall_rise_ignored");
    step(8'h01, 2'b01, 8'h00, 1'b0, 8'h02, 8'h06, 4'd5, 1'b1, "fall_pulse");
    step(8'hFE, 2'b11, 8'h00, 1'b0, 8'h00, 8'h06, 4'd5, 1'b1, "off");
    step(8'hFF, 2'b00, 8'h00, 1'b0, 8'h01, 8'h07, 4'd6, 1'b1, "mode_switch");

    // Clear priority.
    step(8'hFF, 2'b00, 8'hFF, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, "clr_all");
    step(8'hFE, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "clr_setup");
    step(8'hFF, 2'b00, 8'h00, 1'b0, 8'h01, 8'h01, 4'd1, 1'b1, "clr_cap_set");
    step(8'hFE, 2'b00, 8'h00, 1'b0, 8'h00, 8'h01, 4'd1, 1'b1, "clr_fall");
    step(8'hFF, 2'b00, 8'h01, 1'b0, 8'h01, 8'h01, 4'd2, 1'b1, "clr_set_wins");
    step(8'hFF, 2'b00, 8'h01, 1'b0, 8'h00, 8'h00, 4'd2, 1'b0, "clr_no_edge");

    // Saturation at 15 with CNT_W=4.
    step(8'hFF, 2'b10, 8'h00, 1'b1, 8'h00, 8'h00, 4'd0,  1'b0, "sat_clr");
    step(8'h00, 2'b10, 8'h00, 1'b0, 8'hFF, 8'hFF, 4'd8,  1'b1, "sat_8");
    step(8'hFF, 2'b10, 8'h00, 1'b0, 8'hFF, 8'hFF, 4'd15, 1'b1, "sat_15");
    step(8'h00, 2'b10, 8'h00, 1'b0, 8'hFF, 8'hFF, 4'd15, 1'b1, "sat_hold");
    step(8'hFF, 2'b10, 8'h00, 1'b0, 8'hFF, 8'hFF, 4'd15, 1'b1, "sat_hold2");
    step(8'h00, 2'b10, 8'h00, 1'b1, 8'hFF, 8'hFF, 4'd8,  1'b1, "sat_clr_toggle");
    step(8'h00, 2'b10, 8'h00, 1'b0, 8'h00, 8'hFF, 4'd8,  1'b1, "sat_idle");
    step(8'h00, 2'b10, 8'h00, 1'b1, 8'h00, 8'hFF, 4'd0,  1'b1, "sat_clr_only");

    // Asynchronous reset between edges.
    in_v = 8'h01;
    mode = 2'b00;
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("async_rst_held");
    @(negedge clk);
    resetn = 1'b1;
    step(8'h01, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "reprime0");
    step(8'h01, 2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "reprime1");
    step(8'h03, 2'b00, 8'h00, 1'b0, 8'h02, 8'h02, 4'd1, 1'b1, "reprime_rise");

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_edge_capture_n
